adrv9001_tx_stream_buf: RTL

//  TX sample elastic buffer between the user/DMA AXIS source and the ADRV9001 TX SSI channel s_axis port.

---
 rtl/adrv9001_tx_stream_buf_pkg.sv | 15 +
 rtl/adrv9001_tx_fifo_mem.sv | 23 ++
 rtl/adrv9001_tx_stream_buf.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adrv9001_tx_stream_buf_pkg.sv
// Shared definitions for the ADRV9001 TX sample buffer: IQ width, filler modes, control states.
package adrv9001_tx_stream_buf_pkg;

  localparam int ADRV9001_IQ_W = 32;

  localparam logic ADRV9001_UF_ZERO   = 1'b0;
  localparam logic ADRV9001_UF_REPEAT = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_PREFILL = 2'd1,
    TX_RUN     = 2'd2
  } tx_buf_state_t;

endpackage

// File: rtl/adrv9001_tx_fifo_mem.sv
// Single-clock simple dual-port sample RAM; write lands on the clock edge, read is combinational.
// No reset on the array: contents are only ever read behind the level count.
module adrv9001_tx_fifo_mem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adrv9001_tx_stream_buf.sv
// TX elastic buffer: prefill to a threshold, then stream one word per m_axis_tready (one register stage).
// Upstream stalls only when memory is full; downstream never stalls -- empty slots get filler words.
module adrv9001_tx_stream_buf
  import adrv9001_tx_stream_buf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DEPTH_LOG2:0]      start_level,
  input  logic                     uf_mode,
  input  logic [ADRV9001_IQ_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [ADRV9001_IQ_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DEPTH_LOG2:0]      level,
  output logic                     running,
  output logic                     underflow,
  output logic [15:0]              uf_count
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH = LW'(2**DEPTH_LOG2);

  tx_buf_state_t           state;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [ADRV9001_IQ_W-1:0] head;
  logic [LW-1:0]           eff_start;
  logic                    push;
  logic                    pop;
  logic                    uf_slot;

  always_comb begin
    eff_start = start_level;
    if (start_level == '0)
      eff_start = LW'(1);
    else if (start_level > DEPTH)
      eff_start = DEPTH;
  end

  assign s_axis_tready = (state != TX_IDLE) && (level < DEPTH);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign running       = (state == TX_RUN);

  // A consumer slot with nothing stored becomes a filler slot instead of a pop.
  always_comb begin
    pop     = 1'b0;
    uf_slot = 1'b0;
    case (state)
      TX_PREFILL: pop = (level >= eff_start);
      TX_RUN: begin
        if (m_axis_tready) begin
          if (level != '0) pop = 1'b1;
          else             uf_slot = 1'b1;
        end
      end
      default: ;
    endcase
  end

  adrv9001_tx_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (ADRV9001_IQ_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= TX_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      underflow     <= 1'b0;
      uf_count      <= '0;
    end else if (!enable) begin
      // Flush everything but the underflow tally, which software reads after stopping.
      state         <= TX_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      level <= level + LW'(push) - LW'(pop);
      case (state)
        TX_IDLE: begin
          state    <= TX_PREFILL;
          uf_count <= '0;
        end
        TX_PREFILL: begin
          if (pop) begin
            m_axis_tdata  <= head;
            m_axis_tvalid <= 1'b1;
            state         <= TX_RUN;
          end
        end
        TX_RUN: begin
          if (pop) begin
            m_axis_tdata <= head;
          end else if (uf_slot) begin
            if (uf_mode == ADRV9001_UF_ZERO) m_axis_tdata <= '0;
            underflow <= 1'b1;
            if (uf_count != 16'hFFFF) uf_count <= uf_count + 16'd1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule
